// File: rtl/gate_check_pkg.sv
// Shared definitions for the gate truth-table checkers: FSM state encoding,
// reference truth tables for common 3-input gates, and a timer sizing helper.
package gate_check_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Bit i of each table is the gate output for input vector i.
  localparam logic [7:0] TT_NAND3 = 8'h7F;
  localparam logic [7:0] TT_AND3  = 8'h80;
  localparam logic [7:0] TT_OR3   = 8'hFE;
  localparam logic [7:0] TT_NOR3  = 8'h01;
  localparam logic [7:0] TT_XOR3  = 8'h96;

  // A settle time of 1 needs only a constant-zero reload, but a 1-bit counter keeps widths legal.
  function automatic int timer_width(input int settle);
    return (settle > 1) ? $clog2(settle) : 1;
  endfunction

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter that measures how long each stimulus vector is held.
// It stops at zero and flags it so the checker knows the gate output has settled.
module settle_timer #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             zero
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= value;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - WIDTH'(1);
    end
  end

  assign zero = (r_cnt == '0);

endmodule

// File: rtl/gate_truth_table_checker.sv
// Exhaustive response checker: sweeps every input vector onto a small gate,
// waits SETTLE cycles, then compares the gate output with the EXPECT table.
module gate_truth_table_checker
  import gate_check_pkg::*;
#(
  parameter int                   N_IN   = 3,
  parameter logic [(1<<N_IN)-1:0] EXPECT = TT_NAND3,
  parameter int                   SETTLE = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic [N_IN-1:0] stim,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_fail,
  output logic            first_fail_valid
);

  localparam int              TW          = timer_width(SETTLE);
  localparam logic [TW-1:0]   SETTLE_LOAD = TW'(SETTLE - 1);
  localparam logic [N_IN-1:0] STIM_LAST   = '1;

  state_t          r_state;
  logic [N_IN-1:0] r_stim;
  logic [N_IN:0]   r_err;
  logic [N_IN-1:0] r_ff;
  logic            r_ffv;
  logic            r_busy;
  logic            r_done;
  logic            r_pass;

  state_t          w_next;
  logic [N_IN-1:0] w_stim;
  logic [N_IN:0]   w_err;
  logic [N_IN-1:0] w_ff;
  logic            w_ffv;
  logic            w_load;
  logic            w_zero;
  logic            w_mismatch;

  settle_timer #(
    .WIDTH(TW)
  ) u_timer (
    .clk  (clk),
    .reset(reset),
    .load (w_load),
    .value(SETTLE_LOAD),
    .zero (w_zero)
  );

  assign w_mismatch = (dut_out != EXPECT[r_stim]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Start is only honoured from IDLE or DONE, so a pulse mid-sweep falls through untouched.
  always_comb begin
    w_next = r_state;
    w_stim = r_stim;
    w_err  = r_err;
    w_ff   = r_ff;
    w_ffv  = r_ffv;
    w_load = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_next = ST_SETTLE;
          w_stim = '0;
          w_err  = '0;
          w_ff   = '0;
          w_ffv  = 1'b0;
          w_load = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (w_zero) begin
          w_next = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (w_mismatch) begin
          w_err = r_err + (N_IN+1)'(1);
          if (!r_ffv) begin
            w_ff  = r_stim;
            w_ffv = 1'b1;
          end
        end
        if (r_stim == STIM_LAST) begin
          w_next = ST_DONE;
        end else begin
          w_stim = r_stim + N_IN'(1);
          w_load = 1'b1;
          w_next = ST_SETTLE;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Status flags are registered from the next-state values so they line up with the state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stim <= '0;
      r_err  <= '0;
      r_ff   <= '0;
      r_ffv  <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_pass <= 1'b0;
    end else begin
      r_stim <= w_stim;
      r_err  <= w_err;
      r_ff   <= w_ff;
      r_ffv  <= w_ffv;
      r_busy <= (w_next == ST_SETTLE) || (w_next == ST_CHECK);
      r_done <= (w_next == ST_DONE);
      r_pass <= (w_next == ST_DONE) && (w_err == '0);
    end
  end

  assign stim             = r_stim;
  assign busy             = r_busy;
  assign done             = r_done;
  assign pass             = r_pass;
  assign err_count        = r_err;
  assign first_fail       = r_ff;
  assign first_fail_valid = r_ffv;

endmodule

// File: doc/gate_truth_table_checker.md
Name: gate_truth_table_checker

Overview:
Synthesizable response checker for small combinational gates, the receiving end of the exhaustive stimulus sweep used by the gate testbenches.
- Drives every input vector 0 .. 2^N_IN-1 onto the gate under test.
- Waits a programmable settle time, samples the gate output and compares it against a parameterized truth table.
- Reports mismatch count, first failing vector, and pass/done.
- Sits beside the DUT on the board or in a bench, replacing hand-inspection of waveforms.

Parameters:
N_IN, 3, number of gate inputs (1..6)
EXPECT, 8'h7F, expected output truth table, width 2^N_IN; bit i = expected output for input vector i (default = 3-input NAND)
SETTLE, 2, clock cycles each vector is held before sampling (>=1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  single-cycle pulse; begins a sweep when in IDLE or DONE
stim  out  N_IN  vector driven to gate inputs; stim[N_IN-1] = MSB
dut_out  in  1  gate output under test, assumed stable within SETTLE cycles
busy  out  1  high during SETTLE and CHECK states
done  out  1  high in DONE state, held until next start or reset
pass  out  1  valid while done: 1 iff err_count == 0
err_count  out  N_IN+1  number of mismatching vectors in the current/last sweep (max 2^N_IN, no saturation needed)
first_fail  out  N_IN  lowest input vector that mismatched
first_fail_valid  out  1  high once any mismatch is recorded in the current sweep

Behaviour:
- Reset (async, active-high): state=IDLE; stim=0, busy=0, done=0, pass=0, err_count=0, first_fail=0, first_fail_valid=0, settle counter=0. Reset asserted mid-sweep aborts immediately with the same values; no partial results are kept.
- States: IDLE, SETTLE, CHECK, DONE. One-hot or binary encoding, implementer's choice.
- IDLE: outputs hold reset values. On start: next state SETTLE, stim=0, cnt=SETTLE-1, err_count=0, first_fail_valid=0, first_fail=0.
- SETTLE: stim held; cnt decrements each cycle. When cnt==0, next state is CHECK.
- CHECK (one cycle): compare dut_out against EXPECT[stim].
  - On mismatch, err_count increments.
  - If first_fail_valid==0, first_fail<=stim and first_fail_valid<=1.
  - If stim == all-ones, next state DONE and stim holds its final value.
  - Otherwise stim<=stim+1, cnt<=SETTLE-1, next state SETTLE.
- Timing: each vector occupies exactly SETTLE+1 cycles (SETTLE in SETTLE state, 1 in CHECK). done rises 2^N_IN*(SETTLE+1) cycles after the clock edge that accepts start. Default: 24 cycles.
- DONE: done=1, busy=0, pass=(err_count==0). err_count, first_fail and first_fail_valid are held. start restarts a sweep exactly as from IDLE, and done drops on the accepting edge.
- start asserted while busy is ignored, with no effect on stim or counters.
- Output registering: stim, busy, done, pass are registered and change only on clk edges. pass is 0 outside DONE.
- dut_out is sampled only in CHECK. Its value in other states is don't-care.
- A mismatch on the final vector is counted before DONE is entered, so pass reflects all 2^N_IN vectors.

Decomposition:
- Shared package (gate_check_pkg): state encoding constants (ST_IDLE, ST_SETTLE, ST_CHECK, ST_DONE) and the default truth-table constants for NAND3, AND3, OR3, NOR3, XOR3. Other gate checkers reuse these.
- One natural sub-module, settle_timer: loadable down-counter with input load, value SETTLE-1, and output zero flag.
- FSM, stimulus counter and error bookkeeping stay in the top module.

Test Plan:
- Behavioural NAND3 connected, EXPECT=8'h7F, SETTLE=2, start pulse -> stim steps 0..7, 3 cycles per vector; done at cycle 24; pass=1, err_count=0, first_fail_valid=0.
- AND3 model connected, EXPECT=8'h7F -> all 8 vectors mismatch; done with pass=0, err_count=8, first_fail=3'b000, first_fail_valid=1.
- dut_out tied to 1 -> only vector 3'b111 mismatches; err_count=1, first_fail=3'b111, pass=0.
- start pulsed again during cycle 10 of a sweep -> ignored; sweep completes at cycle 24 with unchanged results. A start pulse in DONE -> err_count clears and a new 24-cycle sweep runs.
- reset asserted asynchronously mid-SETTLE at vector 4 -> all outputs go to 0 immediately, without waiting for clk; after release state is IDLE, and a subsequent start gives a full clean sweep.
- SETTLE=1, N_IN=2, EXPECT=4'b0111 with a NAND2 model -> done after 8 cycles, pass=1.
